rom_bootloader: RTL and testbench

Hardware bootloader that sits directly upstream of the instruction ROM and the CPU core. It consumes a byte stream from a host link, assembles 16-bit instruction words, and writes them into the ROM through the bootload port. During loading it drives the ROM address/data mux select and holds the CPU in reset. It releases reset after a fixed holdoff once a complete, verified image is written. This replaces the hand-driven bootload sequence the benches use today.

---
 rtl/boot_pkg.sv | 26 ++
 rtl/boot_word_packer.sv | 42 ++++
 rtl/rom_bootloader.sv | 140 ++++++++++++++
 tb/tb_rom_bootloader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
`timescale 1ns/1ps
// Shared types and default constants for the ROM bootloader.
package boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_CHECK,
        ST_HOLD,
        ST_RUN,
        ST_ERROR
    } boot_state_t;

    localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;
    localparam int         BOOT_HOLDOFF   = 3;

    // States in which this block owns the ROM write port.
    function automatic logic drives_rom(input boot_state_t s);
        return (s == ST_COUNT) || (s == ST_HI) || (s == ST_LO) ||
               (s == ST_WRITE) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/boot_word_packer.sv
`timescale 1ns/1ps
// Assembles two bytes (high first) into a 16-bit word and keeps a running XOR
// of every data byte for the frame checksum.
module boot_word_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_strobe,
    input  logic        phase,
    input  logic [7:0]  data_byte,
    output logic [15:0] word,
    output logic [7:0]  checksum
);

    logic [15:0] word_reg;
    logic [7:0]  checksum_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            word_reg     <= '0;
            checksum_reg <= '0;
        end else begin
            if (clear) begin
                checksum_reg <= '0;
            end else if (byte_strobe) begin
                checksum_reg <= checksum_reg ^ data_byte;
            end
            // phase 0 is the high byte, phase 1 the low byte
            if (byte_strobe) begin
                if (phase) begin
                    word_reg[7:0] <= data_byte;
                end else begin
                    word_reg[15:8] <= data_byte;
                end
            end
        end
    end

    assign word     = word_reg;
    assign checksum = checksum_reg;

endmodule

// File: rtl/rom_bootloader.sv
`timescale 1ns/1ps
// rom_bootloader: loads a framed byte stream into the instruction ROM and holds
// the CPU in reset until done. Trailing checksum enabled by ROM_BOOTLOADER_CHECKSUM_EN.
module rom_bootloader
    import boot_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR      = 8'h00,
    parameter int         HOLDOFF_CYCLES = BOOT_HOLDOFF,
    parameter logic [7:0] SYNC_BYTE      = BOOT_SYNC_BYTE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        bootloadStatus,
    output logic [7:0]  bootloadAddress,
    output logic [15:0] bootloadIn,
    output logic        romWE,
    output logic        cpuReset,
    output logic        load_done,
    output logic        load_error
);

    localparam int            HW        = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    boot_state_t   state_reg, state_next;
    logic [8:0]    remaining_reg;
    logic [HW-1:0] hold_cnt_reg;
    logic [7:0]    addr_reg;
    logic          in_ready_reg, status_reg, rom_we_reg, cpu_reset_reg, done_reg;
    logic [7:0]    checksum;
    logic          accept, is_sync, start, data_strobe;

    assign accept      = in_valid && in_ready_reg;
    assign is_sync     = accept && (in_data == SYNC_BYTE);
    assign start       = (state_next == ST_COUNT) && (state_reg != ST_COUNT);
    assign data_strobe = accept && ((state_reg == ST_HI) || (state_reg == ST_LO));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_RUN: if (is_sync) state_next = ST_COUNT;
            ST_COUNT:        if (accept) state_next = ST_HI;
            ST_HI:           if (accept) state_next = ST_LO;
            ST_LO:           if (accept) state_next = ST_WRITE;
            ST_WRITE: begin
                if (remaining_reg == 9'd1) begin
`ifdef ROM_BOOTLOADER_CHECKSUM_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_HOLD;
`endif
                end else begin
                    state_next = ST_HI;
                end
            end
`ifdef ROM_BOOTLOADER_CHECKSUM_EN
            ST_CHECK:        if (accept) state_next = (in_data == checksum) ? ST_HOLD : ST_ERROR;
            ST_ERROR:        if (is_sync) state_next = ST_COUNT;
`endif
            ST_HOLD:         if (hold_cnt_reg == HOLD_LAST) state_next = ST_RUN;
            default:         state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered images of the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            hold_cnt_reg  <= '0;
            addr_reg      <= BASE_ADDR;
            in_ready_reg  <= 1'b1;
            status_reg    <= 1'b0;
            rom_we_reg    <= 1'b0;
            cpu_reset_reg <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next != ST_WRITE) && (state_next != ST_HOLD);
            status_reg    <= drives_rom(state_next);
            rom_we_reg    <= (state_next == ST_WRITE);
            cpu_reset_reg <= (state_next != ST_RUN);
            done_reg      <= (state_next == ST_RUN);
            hold_cnt_reg  <= (state_reg == ST_HOLD) ? hold_cnt_reg + 1'b1 : '0;

            if (start) begin
                addr_reg <= BASE_ADDR;
            end else if (state_reg == ST_WRITE) begin
                addr_reg <= addr_reg + 8'd1;
            end

            if (state_reg == ST_COUNT && accept) begin
                remaining_reg <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            end else if (state_reg == ST_WRITE) begin
                remaining_reg <= remaining_reg - 9'd1;
            end
        end
    end

`ifdef ROM_BOOTLOADER_CHECKSUM_EN
    logic error_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            error_reg <= 1'b0;
        end else begin
            error_reg <= (state_next == ST_ERROR);
        end
    end

    assign load_error = error_reg;
`else
    logic [7:0] checksum_unused;

    assign checksum_unused = checksum;
    assign load_error      = 1'b0;
`endif

    boot_word_packer u_packer (
        .clock       (clock),
        .reset       (reset),
        .clear       (start),
        .byte_strobe (data_strobe),
        .phase       (state_reg == ST_LO),
        .data_byte   (in_data),
        .word        (bootloadIn),
        .checksum    (checksum)
    );

    assign in_ready        = in_ready_reg;
    assign bootloadStatus  = status_reg;
    assign bootloadAddress = addr_reg;
    assign romWE           = rom_we_reg;
    assign cpuReset        = cpu_reset_reg;
    assign load_done       = done_reg;

endmodule

// File: tb/tb_rom_bootloader.sv
`timescale 1ns/1ps
// Self-checking bench for rom_bootloader: frames are sent by tasks, expected ROM
// writes go to a queue and are popped by a write monitor.
module tb_rom_bootloader;

    localparam logic [7:0] BASE = 8'h00;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, bootloadStatus, romWE, cpuReset, load_done, load_error;
    logic [7:0]  bootloadAddress;
    logic [15:0] bootloadIn;

    int          checks = 0;
    int          errors = 0;
    int          write_count = 0;
    logic [23:0] exp_q[$];
    logic [15:0] rom_model [0:255];
    logic [15:0] frame_words [0:255];

    rom_bootloader dut (
        .clock           (clock),
        .reset           (reset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .bootloadStatus  (bootloadStatus),
        .bootloadAddress (bootloadAddress),
        .bootloadIn      (bootloadIn),
        .romWE           (romWE),
        .cpuReset        (cpuReset),
        .load_done       (load_done),
        .load_error      (load_error)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ROM write monitor and scoreboard
    initial begin
        logic [23:0] got, want;
        forever begin
            @(negedge clock);
            if (romWE) begin
                write_count++;
                rom_model[bootloadAddress] = bootloadIn;
                got = {bootloadAddress, bootloadIn};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual=%h required=none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL rom_write actual=%h required=%h", got, want);
                    end
                end
                checks++;
                if (bootloadStatus !== 1'b1) begin
                    errors++;
                    $display("FAIL status_during_write actual=%b required=1", bootloadStatus);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        @(negedge clock);
        if (gap) @(negedge clock);
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=%b required=1", in_ready);
        end
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit gap, input bit bad_cks);
        logic [7:0] cks;
        logic [7:0] addr;
        logic [7:0] cnt;
        cks  = 8'h00;
        addr = BASE;
        cnt  = n[7:0];
        send_byte(8'hA5, gap);
        send_byte(cnt, gap);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({addr, frame_words[i]});
            addr = addr + 8'd1;
            send_byte(frame_words[i][15:8], gap);
            send_byte(frame_words[i][7:0], gap);
            cks = cks ^ frame_words[i][15:8] ^ frame_words[i][7:0];
        end
`ifdef ROM_BOOTLOADER_CHECKSUM_EN
        send_byte(bad_cks ? (cks ^ 8'h5A) : cks, gap);
`else
        if (bad_cks) cks = 8'h00;
`endif
    endtask

    task automatic wait_finished();
        int n;
        n = 0;
        @(negedge clock);
        while (!(load_done || load_error) && n < 80) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!(load_done || load_error)) begin
            errors++;
            $display("FAIL load_finish_timeout actual=%b%b required=done_or_error", load_done, load_error);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({bootloadStatus, bootloadAddress, bootloadIn, romWE, cpuReset, load_done, load_error, in_ready}
            !== {1'b0, BASE, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values actual=%b/%h/%h/%b/%b/%b/%b/%b required=0/%h/0000/0/1/0/0/1",
                     bootloadStatus, bootloadAddress, bootloadIn, romWE, cpuReset, load_done, load_error, in_ready, BASE);
        end
        reset = 1'b0;
    endtask

    task automatic test_discard();
        int wc0;
        wc0 = write_count;
        send_byte(8'h00, 1'b0);
        send_byte(8'h3C, 1'b0);
        repeat (3) @(negedge clock);
        checks++;
        if (write_count != wc0) begin
            errors++;
            $display("FAIL discard_writes actual=%0d required=%0d", write_count, wc0);
        end
        checks++;
        if ({bootloadStatus, cpuReset, load_done, in_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL discard_idle actual=%b required=0101", {bootloadStatus, cpuReset, load_done, in_ready});
        end
    endtask

    task automatic test_basic();
        int wc0, n;
        wc0 = write_count;
        frame_words[0] = 16'h1121;
        frame_words[1] = 16'h1121;
        send_frame(2, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bootloadStatus && n < 20);
        n = 0;
        while (cpuReset && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL holdoff_cycles actual=%0d required=3", n);
        end
        checks++;
        if (write_count - wc0 != 2) begin
            errors++;
            $display("FAIL basic_write_count actual=%0d required=2", write_count - wc0);
        end
        checks++;
        if (rom_model[0] !== 16'h1121 || rom_model[1] !== 16'h1121) begin
            errors++;
            $display("FAIL basic_rom actual=%h,%h required=1121,1121", rom_model[0], rom_model[1]);
        end
        checks++;
        if ({load_done, cpuReset, load_error, bootloadStatus} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_run actual=%b required=1000", {load_done, cpuReset, load_error, bootloadStatus});
        end
    endtask

`ifdef ROM_BOOTLOADER_CHECKSUM_EN
    task automatic test_checksum_error();
        send_frame(2, 1'b0, 1'b1);
        wait_finished();
        repeat (5) @(negedge clock);
        checks++;
        if ({load_error, cpuReset, load_done, bootloadStatus} !== 4'b1100) begin
            errors++;
            $display("FAIL cks_error actual=%b required=1100", {load_error, cpuReset, load_done, bootloadStatus});
        end
        send_frame(2, 1'b0, 1'b0);
        wait_finished();
        checks++;
        if ({load_done, load_error, cpuReset} !== 3'b100) begin
            errors++;
            $display("FAIL cks_recover actual=%b required=100", {load_done, load_error, cpuReset});
        end
    endtask
`endif

    task automatic test_wrap();
        int wc0;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            frame_words[i] = {b ^ 8'hC3, b};
        end
        wc0 = write_count;
        send_frame(256, 1'b0, 1'b0);
        wait_finished();
        checks++;
        if (write_count - wc0 != 256) begin
            errors++;
            $display("FAIL wrap_write_count actual=%0d required=256", write_count - wc0);
        end
        checks++;
        if (bootloadAddress !== 8'h00 || load_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_end actual=%h/%b required=00/1", bootloadAddress, load_done);
        end
        checks++;
        if (rom_model[0] !== 16'hC300 || rom_model[255] !== 16'h3CFF) begin
            errors++;
            $display("FAIL wrap_rom actual=%h,%h required=c300,3cff", rom_model[0], rom_model[255]);
        end
    endtask

    task automatic test_midreset();
        int wc0;
        wc0 = write_count;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({bootloadStatus, cpuReset, load_done, in_ready, bootloadAddress} !== {4'b0101, BASE}) begin
            errors++;
            $display("FAIL midreset_idle actual=%b/%h required=0101/%h",
                     {bootloadStatus, cpuReset, load_done, in_ready}, bootloadAddress, BASE);
        end
        repeat (6) @(negedge clock);
        checks++;
        if (write_count != wc0 || cpuReset !== 1'b1) begin
            errors++;
            $display("FAIL midreset_nowrite actual=%0d/%b required=%0d/1", write_count, cpuReset, wc0);
        end
    endtask

    task automatic test_stall();
        int wc0;
        frame_words[0] = 16'hBEEF;
        frame_words[1] = 16'h1234;
        frame_words[2] = 16'h00FF;
        wc0 = write_count;
        send_frame(3, 1'b1, 1'b0);
        wait_finished();
        checks++;
        if (write_count - wc0 != 3) begin
            errors++;
            $display("FAIL stall_write_count actual=%0d required=3", write_count - wc0);
        end
        checks++;
        if (rom_model[0] !== 16'hBEEF || rom_model[1] !== 16'h1234 || rom_model[2] !== 16'h00FF) begin
            errors++;
            $display("FAIL stall_rom actual=%h,%h,%h required=beef,1234,00ff", rom_model[0], rom_model[1], rom_model[2]);
        end
        checks++;
        if (exp_q.size() != 0 || load_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_end actual=%0d/%b required=0/1", exp_q.size(), load_done);
        end
    endtask

    initial begin
        test_reset();
        test_discard();
        test_basic();
`ifdef ROM_BOOTLOADER_CHECKSUM_EN
        test_checksum_error();
`endif
        test_wrap();
        test_midreset();
        test_stall();
        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
